// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA sequencing controller: state encoding,
// operand width and the fixed display/validation constants.
package rsa_pkg;

    localparam int OP_W = 8;

    // Value shown on the display while the controller sits in ERR.
    localparam logic [OP_W-1:0] ERR_CODE = 8'hEE;

    // Smallest modulus the core can accept; anything below is rejected.
    localparam logic [OP_W-1:0] MIN_MOD = 8'd2;

    typedef enum logic [2:0] {
        ST_LOAD_M = 3'd0,
        ST_LOAD_E = 3'd1,
        ST_LOAD_N = 3'd2,
        ST_START  = 3'd3,
        ST_WAIT   = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERR    = 3'd6
    } seq_state_t;

    // True for the three operand-entry states.
    function automatic logic is_load_state(input seq_state_t s);
        return (s == ST_LOAD_M) || (s == ST_LOAD_E) || (s == ST_LOAD_N);
    endfunction

endpackage

// File: rtl/rsa_seq_tmr.sv
// Wait-phase timeout counter. The count is cleared while the core is being
// started and advances once per enabled cycle. "expired" is high during the
// enabled cycle that is the WAIT_MAX-th one since the clear, so the owner
// can leave on the edge that ends exactly WAIT_MAX cycles of waiting.
module rsa_seq_tmr #(
    parameter logic [15:0] WAIT_MAX = 16'd65535
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [15:0] count;

    // Cycle counter; saturates instead of wrapping so it can never re-arm.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != 16'hFFFF)) begin
            count <= count + 16'd1;
        end
    end

    // Current cycle number (count + 1) compared against the limit.
    assign expired = enable && (({1'b0, count} + 17'd1) >= {1'b0, WAIT_MAX});

endmodule

// File: rtl/rsa_seq_ctrl.sv
// Operator-facing sequencer for an 8-bit modular-exponentiation core.
// The operator enters M, E and N through the switches (one seq_load strobe
// each). The controller then pulses seq_core_start once and waits for the
// core. seq_dout carries the value for the binary-to-LCD decoder.
//
// Core handshake: seq_core_start is a one-cycle request. seq_core_rdy is a
// valid strobe that is only looked at in WAIT. seq_core_c is taken on the
// same cycle seq_core_rdy is high. rdy beats a simultaneous timeout.
// seq_state exposes the FSM state for observation.
module rsa_seq_ctrl
    import rsa_pkg::*;
#(
    parameter logic        CLK_EDGE = 1'b1,
    parameter logic [15:0] WAIT_MAX = 16'd65535
) (
    input  logic            seq_clk,
    input  logic            seq_rst,
    input  logic [OP_W-1:0] seq_din,
    input  logic            seq_load,
    input  logic            seq_core_rdy,
    input  logic [OP_W-1:0] seq_core_c,
    output logic [OP_W-1:0] seq_core_m,
    output logic [OP_W-1:0] seq_core_e,
    output logic [OP_W-1:0] seq_core_n,
    output logic            seq_core_start,
    output logic [OP_W-1:0] seq_dout,
    output logic            seq_busy,
    output logic            seq_err,
    output seq_state_t      seq_state
);

    // All registers run on the edge selected by CLK_EDGE.
    logic act_clk;
    assign act_clk = CLK_EDGE ? seq_clk : ~seq_clk;

    seq_state_t      state;
    seq_state_t      state_next;
    logic [OP_W-1:0] m_q;
    logic [OP_W-1:0] e_q;
    logic [OP_W-1:0] n_q;
    logic [OP_W-1:0] res_q;
    logic [OP_W-1:0] dout_q;
    logic [OP_W-1:0] dout_next;
    logic            m_we;
    logic            e_we;
    logic            n_we;
    logic            res_we;
    logic            tmr_clear;
    logic            tmr_en;
    logic            tmr_expired;

    rsa_seq_tmr #(
        .WAIT_MAX (WAIT_MAX)
    ) u_tmr (
        .clk     (act_clk),
        .rst     (seq_rst),
        .clear   (tmr_clear),
        .enable  (tmr_en),
        .expired (tmr_expired)
    );

    // Next-state, register write enables and next display value.
    always_comb begin
        state_next = state;
        m_we       = 1'b0;
        e_we       = 1'b0;
        n_we       = 1'b0;
        res_we     = 1'b0;
        tmr_clear  = 1'b0;
        tmr_en     = 1'b0;
        dout_next  = '0;

        case (state)
            ST_LOAD_M: begin
                if (seq_load) begin
                    m_we       = 1'b1;
                    state_next = ST_LOAD_E;
                end
            end
            ST_LOAD_E: begin
                if (seq_load) begin
                    e_we       = 1'b1;
                    state_next = ST_LOAD_N;
                end
            end
            ST_LOAD_N: begin
                if (seq_load) begin
                    // A modulus below MIN_MOD is rejected without touching N.
                    if (seq_din >= MIN_MOD) begin
                        n_we       = 1'b1;
                        state_next = ST_START;
                    end else begin
                        state_next = ST_ERR;
                    end
                end
            end
            ST_START: begin
                tmr_clear  = 1'b1;
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                tmr_en = 1'b1;
                if (seq_core_rdy) begin
                    res_we     = 1'b1;
                    state_next = ST_DONE;
                end else if (tmr_expired) begin
                    state_next = ST_ERR;
                end
            end
            ST_DONE, ST_ERR: begin
                if (seq_load) begin
                    state_next = ST_LOAD_M;
                end
            end
            default: begin
                state_next = ST_LOAD_M;
            end
        endcase

        if (is_load_state(state)) begin
            dout_next = seq_din;
        end else if (state == ST_DONE) begin
            dout_next = res_q;
        end else if (state == ST_ERR) begin
            dout_next = ERR_CODE;
        end else begin
            dout_next = '0;
        end
    end

    // State register; reset overrides every other input.
    always_ff @(posedge act_clk) begin
        if (seq_rst) begin
            state <= ST_LOAD_M;
        end else begin
            state <= state_next;
        end
    end

    // Operand and result registers; each holds until its own load.
    always_ff @(posedge act_clk) begin
        if (seq_rst) begin
            m_q   <= '0;
            e_q   <= '0;
            n_q   <= '0;
            res_q <= '0;
        end else begin
            if (m_we) begin
                m_q <= seq_din;
            end
            if (e_we) begin
                e_q <= seq_din;
            end
            if (n_we) begin
                n_q <= seq_din;
            end
            if (res_we) begin
                res_q <= seq_core_c;
            end
        end
    end

    // Display register: one cycle behind the state that selected it.
    always_ff @(posedge act_clk) begin
        if (seq_rst) begin
            dout_q <= '0;
        end else begin
            dout_q <= dout_next;
        end
    end

    assign seq_core_m     = m_q;
    assign seq_core_e     = e_q;
    assign seq_core_n     = n_q;
    assign seq_core_start = (state == ST_START);
    assign seq_busy       = (state == ST_START) || (state == ST_WAIT);
    assign seq_err        = (state == ST_ERR);
    assign seq_dout       = dout_q;
    assign seq_state      = state;

endmodule

// File: tb/tb_rsa_seq_ctrl.sv
// Bench for rsa_seq_ctrl. Two instances are used: one with the default
// timeout and one with WAIT_MAX=8. Stimulus and observation are routed to
// whichever instance is selected by sel8.
module tb_rsa_seq_ctrl;
    import rsa_pkg::*;

    // ---------------- clock / reset ----------------
    logic seq_clk = 1'b0;
    always #5 seq_clk = ~seq_clk;

    logic       rst_drv  = 1'b1;
    logic [7:0] din_drv  = 8'h00;
    logic       load_drv = 1'b0;
    logic       rdy_drv  = 1'b0;
    logic [7:0] c_drv    = 8'h00;
    logic       sel8     = 1'b0;

    logic [7:0] m_a, e_a, n_a, dout_a, m_b, e_b, n_b, dout_b;
    logic       start_a, busy_a, err_a, start_b, busy_b, err_b;
    seq_state_t st_a, st_b;

    rsa_seq_ctrl dut (
        .seq_clk(seq_clk), .seq_rst(rst_drv), .seq_din(din_drv),
        .seq_load(load_drv & ~sel8), .seq_core_rdy(rdy_drv & ~sel8),
        .seq_core_c(c_drv), .seq_core_m(m_a), .seq_core_e(e_a),
        .seq_core_n(n_a), .seq_core_start(start_a), .seq_dout(dout_a),
        .seq_busy(busy_a), .seq_err(err_a), .seq_state(st_a)
    );

    rsa_seq_ctrl #(.CLK_EDGE(1'b1), .WAIT_MAX(16'd8)) dut8 (
        .seq_clk(seq_clk), .seq_rst(rst_drv), .seq_din(din_drv),
        .seq_load(load_drv & sel8), .seq_core_rdy(rdy_drv & sel8),
        .seq_core_c(c_drv), .seq_core_m(m_b), .seq_core_e(e_b),
        .seq_core_n(n_b), .seq_core_start(start_b), .seq_dout(dout_b),
        .seq_busy(busy_b), .seq_err(err_b), .seq_state(st_b)
    );

    wire [7:0]  o_m     = sel8 ? m_b : m_a;
    wire [7:0]  o_e     = sel8 ? e_b : e_a;
    wire [7:0]  o_n     = sel8 ? n_b : n_a;
    wire [7:0]  o_dout  = sel8 ? dout_b : dout_a;
    wire        o_start = sel8 ? start_b : start_a;
    wire        o_busy  = sel8 ? busy_b : busy_a;
    wire        o_err   = sel8 ? err_b : err_a;
    wire [2:0]  o_state = sel8 ? st_b : st_a;

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // What the core would return: M^E mod N by repeated multiplication.
    function automatic logic [7:0] modexp(input logic [7:0] m, input logic [7:0] e,
                                          input logic [7:0] n);
        int r = 1 % int'(n);
        for (int i = 0; i < int'(e); i++) r = (r * int'(m)) % int'(n);
        return r[7:0];
    endfunction

    logic [7:0] m_ref = 0, e_ref = 0, n_ref = 0;

    // ---------------- driver: one cycle, with core model ----------------
    int         cycle_no = 0;
    int         core_lat = 0;     // 0 = core never answers
    int         core_arm = 0;
    logic [7:0] core_val = 0;
    int         start_cnt = 0, busy_cnt = 0, wait_at = -1, end_at = -1;

    task automatic cyc();
        @(negedge seq_clk);
        cycle_no++;
        rdy_drv = 1'b0;
        if (core_arm > 0) begin
            core_arm--;
            if (core_arm == 0) begin
                rdy_drv = 1'b1;
                c_drv   = core_val;
            end
        end
        if (o_start) begin
            start_cnt++;
            core_arm = core_lat;
        end
        if (o_busy) busy_cnt++;
        if (o_state == 3'(ST_WAIT) && wait_at < 0) wait_at = cycle_no;
        if ((o_state == 3'(ST_DONE) || o_state == 3'(ST_ERR)) && end_at < 0) end_at = cycle_no;
    endtask

    task automatic do_reset();
        rst_drv = 1'b1; load_drv = 1'b0; rdy_drv = 1'b0; core_arm = 0;
        m_ref = 0; e_ref = 0; n_ref = 0;
        cyc();
        rst_drv = 1'b0;
    endtask

    task automatic load_op(input logic [7:0] v);
        din_drv = v; load_drv = 1'b1;
        cyc();
        load_drv = 1'b0;
    endtask

    task automatic chk_outputs_reset(input string tag);
        chk({tag, "_state"}, o_state, ST_LOAD_M);
        chk({tag, "_start"}, o_start, 0);
        chk({tag, "_busy"},  o_busy, 0);
        chk({tag, "_err"},   o_err, 0);
        chk({tag, "_dout"},  o_dout, 0);
        chk({tag, "_m"},     o_m, 0);
        chk({tag, "_e"},     o_e, 0);
        chk({tag, "_n"},     o_n, 0);
    endtask

    // One full transaction from LOAD_M, checked against the model, ending back in LOAD_M.
    task automatic run(input logic [7:0] m, input logic [7:0] e, input logic [7:0] n,
                       input int lat, input int wmax);
        bit         valid, done;
        int         exp_busy;
        logic [7:0] c;
        valid    = (n >= 8'd2);
        done     = valid && (lat >= 1) && (lat <= wmax);
        c        = valid ? modexp(m, e, n) : 8'h00;
        exp_busy = valid ? 1 + (done ? lat : wmax) : 0;
        core_lat = lat; core_val = c;
        start_cnt = 0; busy_cnt = 0; wait_at = -1; end_at = -1;
        m_ref = m; e_ref = e;
        if (valid) n_ref = n;
        load_op(m); load_op(e); load_op(n);
        for (int g = 0; g < 300 && o_busy; g++) cyc();
        if (o_busy) chk("busy_bound", 1, 0);
        cyc();
        chk("start_pulses", start_cnt, valid ? 1 : 0);
        chk("busy_cycles", busy_cnt, exp_busy);
        chk("end_state", o_state, done ? ST_DONE : ST_ERR);
        chk("end_err", o_err, done ? 0 : 1);
        chk("end_dout", o_dout, done ? c : 8'hEE);
        chk("core_m", o_m, m_ref);
        chk("core_e", o_e, e_ref);
        chk("core_n", o_n, n_ref);
        if (valid) chk("wait_len", end_at - wait_at, done ? lat : wmax);
        load_op(8'h00);
        chk("back_state", o_state, ST_LOAD_M);
        chk("back_err", o_err, 0);
    endtask

    // ---------------- table vectors ----------------
    typedef struct {
        logic [7:0] din;
        logic       load;
        seq_state_t st;
        logic [7:0] dout;
        logic       err;
        logic [7:0] m, e, n;
    } vec_t;
    vec_t vecs[$];

    task automatic add_vec(input logic [7:0] din, input logic load, input seq_state_t st,
                           input logic [7:0] dout, input logic err,
                           input logic [7:0] m, input logic [7:0] e, input logic [7:0] n);
        vec_t v;
        v.din = din; v.load = load; v.st = st; v.dout = dout; v.err = err;
        v.m = m; v.e = e; v.n = n;
        vecs.push_back(v);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        add_vec(8'h05, 1, ST_LOAD_E, 8'h05, 0, 8'h05, 8'h00, 8'h00);
        add_vec(8'h40, 0, ST_LOAD_E, 8'h40, 0, 8'h05, 8'h00, 8'h00);
        add_vec(8'h03, 1, ST_LOAD_N, 8'h03, 0, 8'h05, 8'h03, 8'h00);
        add_vec(8'h21, 0, ST_LOAD_N, 8'h21, 0, 8'h05, 8'h03, 8'h00);
        add_vec(8'h01, 1, ST_ERR,    8'h01, 1, 8'h05, 8'h03, 8'h00);
        add_vec(8'h77, 0, ST_ERR,    8'hEE, 1, 8'h05, 8'h03, 8'h00);
        add_vec(8'h09, 1, ST_LOAD_M, 8'hEE, 0, 8'h05, 8'h03, 8'h00);
        add_vec(8'h12, 0, ST_LOAD_M, 8'h12, 0, 8'h05, 8'h03, 8'h00);
        add_vec(8'hA5, 1, ST_LOAD_E, 8'hA5, 0, 8'hA5, 8'h03, 8'h00);

        // Reset values.
        sel8 = 1'b0;
        do_reset();
        chk_outputs_reset("reset");

        // Table: entry, invalid modulus, display path.
        start_cnt = 0;
        foreach (vecs[i]) begin
            din_drv = vecs[i].din; load_drv = vecs[i].load;
            cyc();
            load_drv = 1'b0;
            chk($sformatf("tbl%0d_state", i), o_state, vecs[i].st);
            chk($sformatf("tbl%0d_dout", i),  o_dout,  vecs[i].dout);
            chk($sformatf("tbl%0d_err", i),   o_err,   vecs[i].err);
            chk($sformatf("tbl%0d_m", i),     o_m,     vecs[i].m);
            chk($sformatf("tbl%0d_e", i),     o_e,     vecs[i].e);
            chk($sformatf("tbl%0d_n", i),     o_n,     vecs[i].n);
        end
        chk("tbl_no_start", start_cnt, 0);

        // Nominal run then back-to-back with only M changed.
        do_reset();
        run(8'd5, 8'd3, 8'd33, 10, 65535);
        chk("retain_e", o_e, 3);
        chk("retain_n", o_n, 33);
        run(8'd7, 8'd3, 8'd33, 10, 65535);

        // Ignored rdy outside WAIT, ignored load in WAIT, then reset mid-WAIT.
        core_lat = 0;
        load_op(8'd2); load_op(8'd5);
        rdy_drv = 1'b1; c_drv = 8'h55;
        cyc();
        chk("rdy_in_load_n", o_state, ST_LOAD_N);
        load_op(8'd11);
        chk("start_state", o_state, ST_START);
        rdy_drv = 1'b1;
        cyc();
        chk("rdy_in_start", o_state, ST_WAIT);
        load_drv = 1'b1;
        cyc();
        load_drv = 1'b0;
        chk("load_in_wait", o_state, ST_WAIT);
        cyc();
        chk("still_wait", o_state, ST_WAIT);
        chk("wait_busy", o_busy, 1);
        chk("wait_dout", o_dout, 0);
        do_reset();
        chk_outputs_reset("midwait_rst");

        // Short-timeout instance: timeout, rdy on the last cycle, then random runs.
        sel8 = 1'b1;
        do_reset();
        chk_outputs_reset("reset8");
        run(8'd2, 8'd5, 8'd11, 0, 8);
        run(8'd3, 8'd4, 8'd7, 8, 8);
        run(8'd9, 8'd2, 8'd13, 9, 8);
        for (int k = 0; k < 30; k++) begin
            logic [7:0] rm, re, rn;
            rm = 8'($urandom_range(0, 255));
            re = 8'($urandom_range(0, 20));
            rn = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 1))
                                             : 8'($urandom_range(2, 255));
            run(rm, re, rn, int'($urandom_range(0, 12)), 8);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rsa_seq_ctrl.md
RSA_SEQ_CTRL -- requirements
Module: rsa_seq_ctrl

Interface
REQ-001 SHALL have parameter CLK_EDGE, default 1'b1: active clock edge (1 = rising, 0 = falling).
REQ-002 SHALL have parameter WAIT_MAX, default 16'd65535: maximum number of cycles spent in WAIT before timeout.
REQ-003 SHALL have port seq_clk, input, 1: the single clock.
REQ-004 SHALL have port seq_rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port seq_din, input, 8: operand value from the switches.
REQ-006 SHALL have port seq_load, input, 1: single-cycle load/advance strobe, already debounced externally.
REQ-007 SHALL have port seq_core_rdy, input, 1: core result valid.
REQ-008 SHALL have port seq_core_c, input, 8: core result C.
REQ-009 SHALL have ports seq_core_m, seq_core_e and seq_core_n, each output, 8: operands M, E and N to the core.
REQ-010 SHALL have port seq_core_start, output, 1: single-cycle core start pulse.
REQ-011 SHALL have port seq_dout, output, 8: value to the display path.
REQ-012 SHALL have port seq_busy, output, 1: high while the core is running.
REQ-013 SHALL have port seq_err, output, 1: error flag (invalid modulus or timeout).

Function
REQ-014 SHALL implement the FSM states LOAD_M, LOAD_E, LOAD_N, START, WAIT, DONE and ERR; LOAD_M is the reset state.
REQ-015 SHALL, on seq_load in LOAD_M, capture seq_din into M and go to LOAD_E; in LOAD_E, capture into E and go to LOAD_N.
REQ-016 SHALL, on seq_load in LOAD_N, capture seq_din into N and go to START if seq_din >= 2; otherwise it SHALL go to ERR and leave N unchanged.
REQ-017 SHALL stay in START for exactly one cycle with seq_core_start=1, clear the timeout counter, then go to WAIT.
REQ-018 SHALL, in WAIT, on seq_core_rdy=1, capture seq_core_c into a result register and go to DONE.
REQ-019 SHALL, in WAIT, increment the timeout counter each cycle; when the count reaches WAIT_MAX with seq_core_rdy=0, go to ERR.
REQ-020 SHALL give seq_core_rdy priority over timeout when both occur on the same cycle (go to DONE).
REQ-021 SHALL ignore seq_core_rdy in all states except WAIT.
REQ-022 SHALL ignore seq_load in START and WAIT.
REQ-023 SHALL, on seq_load in DONE or ERR, go to LOAD_M and clear seq_err; the M, E and N registers keep their values until reloaded.
REQ-024 SHALL hold seq_core_m, seq_core_e and seq_core_n stable from START until the next load in the corresponding state.
REQ-025 SHALL drive seq_busy=1 exactly in START and WAIT.
REQ-026 SHALL drive seq_err=1 exactly in ERR.
REQ-027 SHALL register seq_dout with one-cycle latency, selected by the current state:
- load states: previous-cycle seq_din;
- START or WAIT: 8'h00;
- DONE: the result register;
- ERR: 8'hEE.
REQ-028 SHALL give seq_load in the same cycle as a state entry no effect on that entry; it acts only in the state the FSM is currently in.

Reset
REQ-029 SHALL, on seq_rst=1 at the active edge, force the state to LOAD_M from any state, including mid-WAIT.
REQ-030 SHALL, on reset, clear M, E, N, the result register and the timeout counter to 0.
REQ-031 SHALL, on reset, drive seq_core_start=0, seq_busy=0, seq_err=0 and seq_dout=8'h00.
REQ-032 SHALL give reset priority over seq_load and seq_core_rdy.

Structure
REQ-033 SHALL take the following from shared package rsa_pkg:
- state encoding typedef;
- operand width constant (8);
- ERR_CODE constant (8'hEE);
- minimum modulus constant (2).
REQ-034 SHALL implement the timeout counter as sub-module rsa_seq_tmr, with inputs clear and enable, output expired, and parameter WAIT_MAX.
REQ-035 SHALL be placed between the switch/core interface and the display path, so that seq_dout feeds the binary-to-LCD decoder.

Verification
REQ-036 SHALL cover: load M=5, E=3, N=33; core model asserts rdy with C=26 after 10 cycles -> start high exactly 1 cycle, busy high 11 cycles, dout=8'h1A in DONE.
REQ-037 SHALL cover: load N=1 -> ERR, err=1, dout=8'hEE, start never asserted; seq_load -> LOAD_M, err=0.
REQ-038 SHALL cover: WAIT_MAX=8, core never ready -> ERR exactly 8 cycles after WAIT entry; with rdy on cycle 8 -> DONE (priority).
REQ-039 SHALL cover: rdy pulsed in LOAD_N and START and seq_load pulsed in WAIT -> both ignored, FSM still in WAIT.
REQ-040 SHALL cover: seq_rst asserted mid-WAIT -> next cycle state LOAD_M, all outputs at reset values, M/E/N=0.
REQ-041 SHALL cover: back-to-back run after DONE reloading only M=7 (E=3, N=33 retained) -> C=13 presented, dout=8'h0D.
